// File: rtl/mips_cpu_state_sequencer.sv
// Multicycle HALT/FETCH/DECODE/EXEC1/EXEC2 sequencer with waitrequest stall and watchdog.
// Define STATE_SEQ_PERF_EN to add the instr_count/stall_count performance outputs.
module mips_cpu_state_sequencer #(
    parameter int STALL_LIMIT = 1024,
    parameter int STALL_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        waitrequest,
    input  logic        mem_req,
    input  logic [31:0] pc_next,
    output logic [3:0]  state,
    output logic        active,
    output logic        stall,
    output logic        retire,
`ifdef STATE_SEQ_PERF_EN
    output logic [31:0] instr_count,
    output logic [31:0] stall_count,
`endif
    output logic        bus_error
);

    localparam logic [3:0] ST_HALT   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_EXEC1  = 4'd3;
    localparam logic [3:0] ST_EXEC2  = 4'd4;

    localparam logic [STALL_W-1:0] CNT_MAX  = '1;
    localparam logic [STALL_W-1:0] LIMIT_M1 =
        STALL_W'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);
    localparam bit WDOG_EN = (STALL_LIMIT != 0);

    logic [3:0]         state_q, state_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               bus_error_q, bus_error_d;
    logic               armed_q, armed_d;
    logic               mem_phase;
    logic               wdog_fire;

    // State register; armed_q marks that a reset has occurred and HALT may start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HALT;
            stall_cnt_q <= '0;
            bus_error_q <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            bus_error_q <= bus_error_d;
            armed_q     <= armed_d;
        end
    end

    // Output decode
    always_comb begin
        mem_phase = 1'b0;
        active    = 1'b0;
        unique case (state_q)
            ST_FETCH, ST_EXEC1, ST_EXEC2: begin
                mem_phase = 1'b1;
                active    = 1'b1;
            end
            ST_DECODE: active = 1'b1;
            default: begin
                mem_phase = 1'b0;
                active    = 1'b0;
            end
        endcase
        stall     = mem_phase & mem_req & waitrequest;
        retire    = (state_q == ST_EXEC2) & ~stall;
        state     = state_q;
        bus_error = bus_error_q;
    end

    // A completing access drops stall, so completion always beats the watchdog.
    assign wdog_fire = WDOG_EN && stall && (stall_cnt_q == LIMIT_M1);

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        bus_error_d = bus_error_q;
        armed_d     = armed_q;
        unique case (state_q)
            ST_HALT: begin
                if (armed_q) begin
                    state_d = ST_FETCH;
                    armed_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (wdog_fire) begin
                    state_d     = ST_HALT;
                    bus_error_d = 1'b1;
                end else if (!stall) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC1;
            ST_EXEC1: begin
                if (wdog_fire) begin
                    state_d     = ST_HALT;
                    bus_error_d = 1'b1;
                end else if (!stall) begin
                    state_d = ST_EXEC2;
                end
            end
            ST_EXEC2: begin
                if (wdog_fire) begin
                    state_d     = ST_HALT;
                    bus_error_d = 1'b1;
                end else if (!stall) begin
                    state_d = (pc_next == 32'h0) ? ST_HALT : ST_FETCH;
                end
            end
            default: begin
                state_d     = ST_HALT;
                bus_error_d = 1'b1;
                armed_d     = 1'b0;
            end
        endcase
    end

    // Stall counter: per-access, cleared on every transition, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_d != state_q) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

`ifdef STATE_SEQ_PERF_EN
    logic [31:0] instr_count_q, instr_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    // retire and stall are both zero in HALT, so the counters freeze there.
    always_comb begin
        instr_count_d = instr_count_q + {31'd0, retire};
        stall_count_d = stall_count_q + {31'd0, stall};
        instr_count   = instr_count_q;
        stall_count   = stall_count_q;
    end
`endif

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// Testbench for mips_cpu_state_sequencer: reference model plus scoreboard queue.
// Run with STATE_SEQ_PERF_EN defined to also exercise the performance counters.
module tb_mips_cpu_state_sequencer;

    localparam int LIMIT = 8;
    localparam logic [31:0] PC = 32'hBFC00004;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        waitrequest = 1'b0;
    logic        mem_req = 1'b0;
    logic [31:0] pc_next = PC;
    logic [3:0]  state;
    logic        active, stall, retire, bus_error;
`ifdef STATE_SEQ_PERF_EN
    logic [31:0] instr_count, stall_count;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       act;
        logic       stl;
        logic       ret;
        logic       err;
    } obs_t;

    obs_t sb_q[$];

    int m_state = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;
    bit m_armed = 1'b1;

    mips_cpu_state_sequencer #(.STALL_LIMIT(LIMIT), .STALL_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .waitrequest(waitrequest),
        .mem_req(mem_req),
        .pc_next(pc_next),
        .state(state),
        .active(active),
        .stall(stall),
        .retire(retire),
`ifdef STATE_SEQ_PERF_EN
        .instr_count(instr_count),
        .stall_count(stall_count),
`endif
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_armed = 1'b1;
    endtask

    task automatic model_next(input logic st, input logic [31:0] pcn);
        int  n = m_state;
        bit  fire = st && (m_cnt == LIMIT - 1);
        case (m_state)
            0: if (m_armed) begin n = 1; m_armed = 1'b0; end
            1: if (fire) begin n = 0; m_err = 1'b1; end else if (!st) n = 2;
            2: n = 3;
            3: if (fire) begin n = 0; m_err = 1'b1; end else if (!st) n = 4;
            4: if (fire) begin n = 0; m_err = 1'b1; end
               else if (!st) n = (pcn == 32'h0) ? 0 : 1;
            default: n = 0;
        endcase
        if (n != m_state) m_cnt = 0;
        else if (st) m_cnt++;
        m_state = n;
    endtask

    // One cycle: drive inputs at negedge, push model expectation, sample DUT, pop.
    task automatic step(input logic rst, input logic wr, input logic mr,
                        input logic [31:0] pcn, output obs_t got, output obs_t exp);
        obs_t e;
        @(negedge clk);
        reset = rst;
        waitrequest = wr;
        mem_req = mr;
        pc_next = pcn;
        #1;
        if (rst) begin
            model_reset();
            e = '0;
        end else begin
            e.st  = 4'(m_state);
            e.act = (m_state != 0);
            e.stl = (m_state == 1 || m_state == 3 || m_state == 4) && mr && wr;
            e.ret = (m_state == 4) && !e.stl;
            e.err = m_err;
            model_next(e.stl, pcn);
        end
        sb_q.push_back(e);
        got = {state, active, stall, retire, bus_error};
        exp = sb_q.pop_front();
        cyc++;
    endtask

    task automatic test_reset();
        obs_t g, e;
        step(1'b1, 1'b1, 1'b1, PC, g, e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL reset got=%h exp=%h", g, e);
        end
        total++;
        if ({state, active, stall, retire, bus_error} !== 8'h00) begin
            bad++;
            $display("FAIL reset_direct got=%h exp=00",
                     {state, active, stall, retire, bus_error});
        end
    endtask

    task automatic test_basic();
        obs_t g, e;
        logic [3:0] seq [10];
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, m_state == 1, PC, g, e);
            total++;
            if (g !== e || g.st !== seq[i] || g.ret !== (seq[i] == 4'd4)) begin
                bad++;
                $display("FAIL basic i=%0d got=%h exp=%h seq=%0d", i, g, e, seq[i]);
            end
        end
    endtask

    task automatic test_fetch_stall();
        obs_t g, e;
        int entry, offset, nstall, nfetch, c;
        offset = -1; nstall = 0; nfetch = 0;
        for (int k = 0; k < 8 && m_state != 1; k++) begin
            step(1'b0, 1'b0, m_state == 1, PC, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL fstall_pre got=%h exp=%h", g, e); end
        end
        entry = cyc;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, i < 3, 1'b1, PC, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL fstall i=%0d got=%h exp=%h", i, g, e); end
            if (g.st == 4'd1) nfetch++;
            if (g.stl) nstall++;
        end
        for (int k = 0; k < 10 && offset < 0; k++) begin
            c = cyc;
            step(1'b0, 1'b0, 1'b0, PC, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL fstall_post got=%h exp=%h", g, e); end
            if (g.ret) offset = c - entry;
        end
        total++;
        if (offset != 6 || nfetch != 4 || nstall != 3) begin
            bad++;
            $display("FAIL fstall_latency offset=%0d fetch=%0d stall=%0d exp 6/4/3",
                     offset, nfetch, nstall);
        end
    endtask

    task automatic test_back_to_back();
        obs_t g, e;
        int w1 = 2, w2 = 1;
        logic wr, mr;
        for (int k = 0; k < 8 && m_state != 1; k++) begin
            step(1'b0, 1'b0, m_state == 1, PC, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL b2b_pre got=%h exp=%h", g, e); end
        end
        for (int k = 0; k < 14; k++) begin
            mr = (m_state == 1 || m_state == 3 || m_state == 4);
            wr = 1'b0;
            if (m_state == 3 && w1 > 0) begin wr = 1'b1; w1--; end
            if (m_state == 4 && w2 > 0) begin wr = 1'b1; w2--; end
            step(1'b0, wr, mr, PC, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL b2b k=%0d got=%h exp=%h", k, g, e); end
        end
    endtask

    task automatic test_limit_boundary();
        obs_t g, e;
        int nret = 0;
        for (int k = 0; k < 8 && m_state != 4; k++) begin
            step(1'b0, 1'b0, m_state == 1, PC, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL bound_pre got=%h exp=%h", g, e); end
        end
        for (int i = 0; i < LIMIT; i++) begin
            step(1'b0, i < LIMIT - 1, 1'b1, PC, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL bound i=%0d got=%h exp=%h", i, g, e); end
            if (g.ret) nret++;
        end
        step(1'b0, 1'b0, 1'b1, PC, g, e);
        total++;
        if (nret != 1 || g.err !== 1'b0 || g.st !== 4'd1) begin
            bad++;
            $display("FAIL bound_complete ret=%0d err=%b st=%0d exp 1/0/1", nret, g.err, g.st);
        end
    endtask

    task automatic test_halt();
        obs_t g, e;
        for (int k = 0; k < 8 && m_state != 4; k++) begin
            step(1'b0, 1'b0, m_state == 1, PC, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL halt_pre got=%h exp=%h", g, e); end
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, g, e);
        total++;
        if (g !== e || g.ret !== 1'b1) begin
            bad++;
            $display("FAIL halt_retire got=%h exp=%h", g, e);
        end
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'($urandom), 1'($urandom), $urandom, g, e);
            total++;
            if (g !== e || g.st !== 4'd0 || g.act !== 1'b0) begin
                bad++;
                $display("FAIL halt_hold k=%0d got=%h exp=%h", k, g, e);
            end
        end
    endtask

    task automatic test_watchdog();
        obs_t g, e;
        int nstall = 0, nret = 0;
        step(1'b1, 1'b0, 1'b0, PC, g, e);
        total++;
        if (g !== e) begin bad++; $display("FAIL wdog_reset got=%h exp=%h", g, e); end
        for (int k = 0; k < 16; k++) begin
            step(1'b0, m_state == 3, m_state == 1 || m_state == 3, PC, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL wdog k=%0d got=%h exp=%h", k, g, e); end
            if (g.stl) nstall++;
            if (g.ret) nret++;
        end
        total++;
        if (nstall != LIMIT || nret != 0 || g.st !== 4'd0 || g.err !== 1'b1) begin
            bad++;
            $display("FAIL wdog_end stall=%0d ret=%0d st=%0d err=%b exp 8/0/0/1",
                     nstall, nret, g.st, g.err);
        end
    endtask

    task automatic test_async_reset();
        obs_t g, e;
        logic [7:0] now;
        step(1'b1, 1'b0, 1'b0, PC, g, e);
        total++;
        if (g !== e) begin bad++; $display("FAIL async_clear got=%h exp=%h", g, e); end
        for (int k = 0; k < 8 && m_state != 4; k++) begin
            step(1'b0, 1'b0, m_state == 1, PC, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL async_pre got=%h exp=%h", g, e); end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, PC, g, e);
            total++;
            if (g !== e || g.stl !== 1'b1) begin
                bad++;
                $display("FAIL async_stall got=%h exp=%h", g, e);
            end
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        now = {state, active, stall, retire, bus_error};
        total++;
        if (now !== 8'h00) begin
            bad++;
            $display("FAIL async_immediate got=%h exp=00", now);
        end
        model_reset();
        step(1'b1, 1'b1, 1'b1, PC, g, e);
        total++;
        if (g !== e) begin bad++; $display("FAIL async_hold got=%h exp=%h", g, e); end
        step(1'b0, 1'b0, 1'b0, PC, g, e);
        total++;
        if (g !== e) begin bad++; $display("FAIL async_release got=%h exp=%h", g, e); end
        step(1'b0, 1'b0, 1'b1, PC, g, e);
        total++;
        if (g !== e || g.st !== 4'd1) begin
            bad++;
            $display("FAIL async_first_fetch got=%h exp=%h", g, e);
        end
    endtask

`ifdef STATE_SEQ_PERF_EN
    task automatic test_perf();
        obs_t g, e;
        int nret = 0;
        bit used_f = 1'b0, used_e = 1'b0;
        logic wr, mr;
        step(1'b1, 1'b0, 1'b0, PC, g, e);
        total++;
        if (g !== e) begin bad++; $display("FAIL perf_reset got=%h exp=%h", g, e); end
        for (int k = 0; k < 60 && nret < 5; k++) begin
            mr = (m_state == 1) || (m_state == 3 && nret == 3);
            wr = 1'b0;
            if (nret == 1 && m_state == 1 && !used_f) begin wr = 1'b1; used_f = 1'b1; end
            if (nret == 3 && m_state == 3 && !used_e) begin wr = 1'b1; used_e = 1'b1; end
            step(1'b0, wr, mr, PC, g, e);
            total++;
            if (g !== e) begin bad++; $display("FAIL perf k=%0d got=%h exp=%h", k, g, e); end
            if (g.ret) nret++;
        end
        @(negedge clk);
        #1;
        total++;
        if (instr_count !== 32'd5 || stall_count !== 32'd2) begin
            bad++;
            $display("FAIL perf_counts instr=%0d stall=%0d exp 5/2", instr_count, stall_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_fetch_stall();
        test_back_to_back();
        test_limit_boundary();
        test_halt();
        test_watchdog();
        test_async_reset();
`ifdef STATE_SEQ_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
